// File: rtl/switch_cmd_initiator_pkg.sv
// Shared definitions for the single-byte switch-command protocol.
// Holds the command/ack byte constants, the initiator FSM state codes and
// helpers that map a requested switch state (0..3) to its command and ack
// bytes. The switch-box responder imports this same package so that both
// ends agree on the byte values.
package switch_cmd_initiator_pkg;

  localparam logic [7:0] CMD_U = 8'h55;
  localparam logic [7:0] CMD_J = 8'h6A;
  localparam logic [7:0] CMD_F = 8'h66;
  localparam logic [7:0] CMD_W = 8'h77;

  localparam logic [7:0] ACK_P = 8'h50;
  localparam logic [7:0] ACK_R = 8'h52;
  localparam logic [7:0] ACK_S = 8'h53;
  localparam logic [7:0] ACK_T = 8'h54;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_t;

  function automatic logic [7:0] cmd_byte_of(input logic [1:0] sw_state);
    case (sw_state)
      2'd0:    return CMD_U;
      2'd1:    return CMD_J;
      2'd2:    return CMD_F;
      default: return CMD_W;
    endcase
  endfunction

  function automatic logic [7:0] ack_byte_of(input logic [1:0] sw_state);
    case (sw_state)
      2'd0:    return ACK_P;
      2'd1:    return ACK_R;
      2'd2:    return ACK_S;
      default: return ACK_T;
    endcase
  endfunction

endpackage

// File: rtl/switch_cmd_initiator_tx.sv
// uart_byte_tx: 8N1 UART byte serializer with its own baud counter.
// Ports:
//   clk_50   in   main clock
//   rst_n    in   synchronous active-low reset (line returns high next cycle)
//   tx_start in   one-cycle request; taken only while idle
//   tx_byte  in   byte to send, captured with tx_start
//   uart_tx  out  serial line, idle high
//   tx_busy  out  frame in progress
//   tx_done  out  one-cycle pulse in the cycle after the last stop-bit cycle
module uart_byte_tx #(
  parameter logic [12:0] BAUD_DIV = 13'd5208
) (
  input  logic       clk_50,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_byte,
  output logic       uart_tx,
  output logic       tx_busy,
  output logic       tx_done
);

  logic [12:0] baud_cnt;
  logic [3:0]  bit_idx;
  logic [3:0]  next_idx;
  logic [9:0]  frame;

  assign next_idx = bit_idx + 4'd1;

  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      uart_tx  <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      tx_done <= 1'b0;
      if (!tx_busy) begin
        if (tx_start) begin
          tx_busy  <= 1'b1;
          uart_tx  <= 1'b0;
          baud_cnt <= '0;
          bit_idx  <= '0;
        end
      end else if (baud_cnt == BAUD_DIV - 13'd1) begin
        baud_cnt <= '0;
        if (bit_idx == 4'd9) begin
          tx_busy <= 1'b0;
          tx_done <= 1'b1;
          uart_tx <= 1'b1;
        end else begin
          bit_idx <= next_idx;
          uart_tx <= frame[next_idx];
        end
      end else begin
        baud_cnt <= baud_cnt + 13'd1;
      end
    end
  end

  // Frame shift data: {stop, data LSB-first, start}; pure data, no reset.
  always_ff @(posedge clk_50) begin
    if (!tx_busy && tx_start) begin
      frame <= {1'b1, tx_byte, 1'b0};
    end
  end

endmodule

// File: rtl/switch_cmd_initiator.sv
// switch_cmd_initiator: host-side initiator for the single-byte switch
// command protocol. Sends the command byte for the requested state, waits
// for the matching ack, retries on timeout or wrong ack, reports done/err.
// Ports:
//   clk_50     in   main clock
//   rst_n      in   synchronous active-low reset
//   cmd_valid  in   request to set remote switch state
//   cmd_state  in   requested state 0..3
//   cmd_ready  out  high in IDLE; accept on cmd_valid && cmd_ready
//   rx_data    in   byte from UART receiver (clk_50 domain)
//   rx_valid   in   single-cycle strobe for rx_data
//   uart_tx    out  serial line to remote, idle high
//   busy       out  high from accept until the done/err pulse
//   done       out  one-cycle pulse: matching ack received
//   err        out  one-cycle pulse: retries exhausted
//   cur_state  out  last state acked by remote
//   cur_valid  out  cur_state acked at least once since reset
module switch_cmd_initiator
  import switch_cmd_initiator_pkg::*;
#(
  parameter logic [12:0] BAUD_DIV    = 13'd5208,
  parameter logic [23:0] TIMEOUT_CYC = 24'd5000000,
  parameter logic [1:0]  MAX_RETRIES = 2'd2
) (
  input  logic       clk_50,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_state,
  output logic       cmd_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       uart_tx,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] cur_state,
  output logic       cur_valid
);

  state_t      state_q, state_d;
  logic [1:0]  retry_q, retry_d;
  logic [23:0] timer_q;
  logic        tx_start_q, tx_start_d;
  logic        done_d, err_d;
  logic [1:0]  lat_state_q;
  logic [7:0]  cmd_byte_q;
  logic [7:0]  ack_byte_q;
  logic        ack_match, timeout;
  logic        tx_busy, tx_done;

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign ack_match = rx_valid && (rx_data == ack_byte_q);
  assign timeout   = (timer_q == TIMEOUT_CYC - 24'd1);

  always_comb begin
    state_d    = state_q;
    retry_d    = retry_q;
    tx_start_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d    = ST_SEND;
          retry_d    = 2'd0;
          tx_start_d = 1'b1;
        end
      end
      ST_SEND: begin
        if (tx_done) state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        // A match is checked first so it wins over a coincident timeout.
        if (ack_match) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (rx_valid || timeout) begin
          if (retry_q < MAX_RETRIES) begin
            retry_d    = retry_q + 2'd1;
            state_d    = ST_SEND;
            tx_start_d = 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      retry_q    <= 2'd0;
      timer_q    <= '0;
      tx_start_q <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      cur_state  <= 2'd0;
      cur_valid  <= 1'b0;
    end else begin
      state_q    <= state_d;
      retry_q    <= retry_d;
      tx_start_q <= tx_start_d;
      done       <= done_d;
      err        <= err_d;
      // Timer is held at zero outside WAIT_ACK, so each wait starts fresh.
      if (state_q != ST_WAIT_ACK) begin
        timer_q <= '0;
      end else if (!timeout) begin
        timer_q <= timer_q + 24'd1;
      end
      if (done_d) begin
        cur_state <= lat_state_q;
        cur_valid <= 1'b1;
      end
    end
  end

  // Command/ack bytes latched at accept; data only, no reset.
  always_ff @(posedge clk_50) begin
    if (cmd_ready && cmd_valid) begin
      lat_state_q <= cmd_state;
      cmd_byte_q  <= cmd_byte_of(cmd_state);
      ack_byte_q  <= ack_byte_of(cmd_state);
    end
  end

  uart_byte_tx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tx (
    .clk_50   (clk_50),
    .rst_n    (rst_n),
    .tx_start (tx_start_q && !tx_busy),
    .tx_byte  (cmd_byte_q),
    .uart_tx  (uart_tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

endmodule
